// File: rtl/scene_pkg.sv
// Shared types for the runner-display scene sequencer: game states and signed coordinates.
package scene_pkg;
  localparam int COORD_W   = 12;
  localparam int EXT_W     = COORD_W + 4;
  localparam int COORD_MAX = 2 ** (COORD_W - 1) - 1;

  typedef enum logic [1:0] {COUNTDOWN, LOGO, ENTER, PLAY} state_t;
  typedef logic signed [COORD_W-1:0] coord_t;
  // Working width for offset arithmetic; results are truncated back to coord_t.
  typedef logic signed [EXT_W-1:0] ext_t;
endpackage

// File: rtl/button_edge.sv
// Two-flop synchroniser for a raw push button followed by a one-cycle rising-edge pulse.
module button_edge (
  input  logic CLK100MHZ,
  input  logic CPU_RESETN,
  input  logic btn,
  output logic pulse
);
  logic [2:0] sync_q;

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) sync_q <= '0;
    else             sync_q <= {sync_q[1:0], btn};
  end

  assign pulse = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/scene_sequencer.sv
// Frame-driven game-state sequencer: countdown, logo scroll-off, player slide-in, then play with
// lane selection and animated coins. All animation advances on the vsync rising edge.
module scene_sequencer
  import scene_pkg::*;
#(
  parameter int NUM_LANES        = 3,
  parameter int LANE_PITCH       = 100,
  parameter int NUM_COINS        = 3,
  parameter int COUNTDOWN_FRAMES = 5,
  parameter int LOGO_STEP        = 30,
  parameter int LOGO_END         = -600,
  parameter int PLAYER_START     = -170,
  parameter int PLAYER_STEP      = 17,
  parameter int COIN_X0          = 200,
  parameter int COIN_SPACING     = 80,
  parameter int COIN_Y0          = 40,
  parameter int COIN_DY          = 6,
  parameter int COIN_WRAP        = 480
) (
  input  logic   CLK100MHZ,
  input  logic   CPU_RESETN,
  input  logic   vsync,
  input  logic   BTNL,
  input  logic   BTNR,
  input  logic   restart,
  output state_t state,
  output coord_t logo_voffset,
  output coord_t player_hoffset,
  output coord_t player_voffset,
  output coord_t coin_hoffset [NUM_COINS],
  output coord_t coin_voffset [NUM_COINS]
);
  localparam int LANE_W    = $clog2(NUM_LANES);
  localparam int CNT_W     = $clog2(COUNTDOWN_FRAMES + 1);
  localparam int CEN       = (NUM_LANES - 1) / 2;
  localparam int PHASE_MAX = (COIN_WRAP - COIN_Y0) / COIN_DY;
  localparam int X_MAX     = COIN_X0 + (NUM_COINS - 1) * COIN_SPACING
                             + (NUM_COINS - 1 - (NUM_COINS - 1) / 2) * PHASE_MAX;
  localparam logic [LANE_W-1:0] LANE_CEN = LANE_W'(CEN);
  localparam logic [LANE_W-1:0] LANE_MAX = LANE_W'(NUM_LANES - 1);

  if (NUM_LANES < 2 || NUM_COINS < 1 || COIN_WRAP > COORD_MAX || X_MAX > COORD_MAX ||
      LANE_PITCH * CEN > COORD_MAX) begin : g_range_check
    $error("scene_sequencer: parameter set does not fit COORD_W");
  end

  function automatic coord_t coin_h(int i, ext_t ph);
    return coord_t'(ext_t'(COIN_X0) + ext_t'(i * COIN_SPACING)
                    + ext_t'(i - (NUM_COINS - 1) / 2) * ph);
  endfunction

  function automatic coord_t coin_v(ext_t ph);
    return coord_t'(ext_t'(COIN_Y0) + ext_t'(COIN_DY) * ph);
  endfunction

  function automatic coord_t lane_h(logic [LANE_W-1:0] l);
    return coord_t'((ext_t'(LANE_CEN) - ext_t'(l)) * ext_t'(LANE_PITCH));
  endfunction

  logic              vsync_q, tick, edge_l, edge_r, pend_l, pend_r, mv_l, mv_r;
  logic [CNT_W-1:0]  cnt_q;
  logic [LANE_W-1:0] lane_q, lane_nxt;
  ext_t              phase_q, phase_inc, phase_nxt, logo_dec, player_inc;

  button_edge u_btn_l (.CLK100MHZ(CLK100MHZ), .CPU_RESETN(CPU_RESETN), .btn(BTNL), .pulse(edge_l));
  button_edge u_btn_r (.CLK100MHZ(CLK100MHZ), .CPU_RESETN(CPU_RESETN), .btn(BTNR), .pulse(edge_r));

  assign tick = vsync & ~vsync_q;
  // An edge landing on the tick cycle itself still counts for that frame.
  assign mv_l = (pend_l | edge_l) & ~(pend_r | edge_r);
  assign mv_r = (pend_r | edge_r) & ~(pend_l | edge_l);

  assign logo_dec   = ext_t'(logo_voffset) - ext_t'(LOGO_STEP);
  assign player_inc = ext_t'(player_voffset) + ext_t'(PLAYER_STEP);
  assign phase_inc  = phase_q + ext_t'(1);

  always_comb begin
    phase_nxt = phase_inc;
    if (ext_t'(COIN_Y0) + ext_t'(COIN_DY) * phase_inc > ext_t'(COIN_WRAP)) phase_nxt = '0;
  end

  always_comb begin
    lane_nxt = lane_q;
    if (mv_l && lane_q != '0)           lane_nxt = lane_q - 1'b1;
    else if (mv_r && lane_q != LANE_MAX) lane_nxt = lane_q + 1'b1;
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      vsync_q        <= 1'b0;
      state          <= COUNTDOWN;
      cnt_q          <= CNT_W'(COUNTDOWN_FRAMES);
      logo_voffset   <= '0;
      player_voffset <= coord_t'(PLAYER_START);
      player_hoffset <= lane_h(LANE_CEN);
      lane_q         <= LANE_CEN;
      phase_q        <= '0;
      pend_l         <= 1'b0;
      pend_r         <= 1'b0;
      for (int i = 0; i < NUM_COINS; i++) begin
        coin_hoffset[i] <= coin_h(i, '0);
        coin_voffset[i] <= coin_v('0);
      end
    end else begin
      vsync_q <= vsync;
      if (restart) begin
        state          <= COUNTDOWN;
        cnt_q          <= CNT_W'(COUNTDOWN_FRAMES);
        logo_voffset   <= '0;
        player_voffset <= coord_t'(PLAYER_START);
        player_hoffset <= lane_h(LANE_CEN);
        lane_q         <= LANE_CEN;
        phase_q        <= '0;
        pend_l         <= 1'b0;
        pend_r         <= 1'b0;
        for (int i = 0; i < NUM_COINS; i++) begin
          coin_hoffset[i] <= coin_h(i, '0);
          coin_voffset[i] <= coin_v('0);
        end
      end else if (tick) begin
        pend_l <= 1'b0;
        pend_r <= 1'b0;
        unique case (state)
          COUNTDOWN: begin
            if (cnt_q <= CNT_W'(1)) state <= LOGO;
            else                    cnt_q <= cnt_q - 1'b1;
          end
          LOGO: begin
            if (logo_dec <= ext_t'(LOGO_END)) begin
              logo_voffset <= coord_t'(LOGO_END);
              state        <= ENTER;
            end else begin
              logo_voffset <= coord_t'(logo_dec);
            end
          end
          ENTER: begin
            if (!player_inc[EXT_W-1]) begin
              player_voffset <= '0;
              state          <= PLAY;
            end else begin
              player_voffset <= coord_t'(player_inc);
            end
          end
          PLAY: begin
            lane_q         <= lane_nxt;
            player_hoffset <= lane_h(lane_nxt);
            phase_q        <= phase_nxt;
            for (int i = 0; i < NUM_COINS; i++) begin
              coin_hoffset[i] <= coin_h(i, phase_nxt);
              coin_voffset[i] <= coin_v(phase_nxt);
            end
          end
        endcase
      end else begin
        pend_l <= pend_l | edge_l;
        pend_r <= pend_r | edge_r;
      end
    end
  end
endmodule

// File: tb/tb_scene_sequencer.sv
// Bench for scene_sequencer: fixed vector table, closed-form reference model with random
// button/frame stimulus, and hand-built restart, reset and coin-wrap sequences.
module tb_scene_sequencer;
  import scene_pkg::*;

  localparam int CF      = 5;
  localparam int LS      = 30;
  localparam int LE      = -600;
  localparam int PS      = -170;
  localparam int PST     = 17;
  localparam int T_ENTER = CF + (-LE + LS - 1) / LS;
  localparam int T_PLAY  = T_ENTER + (-PS + PST - 1) / PST;
  localparam int PERIOD  = (480 - 40) / 6 + 1;

  logic   CLK100MHZ = 1'b0, CPU_RESETN = 1'b0, vsync = 1'b0;
  logic   BTNL = 1'b0, BTNR = 1'b0, restart = 1'b0;
  state_t state;
  coord_t logo_voffset, player_hoffset, player_voffset;
  coord_t coin_h [3];
  coord_t coin_v [3];

  int total = 0, bad = 0;
  int k = 0;     // ticks since last reset/restart
  int lane = 1;

  scene_sequencer dut (
    .CLK100MHZ(CLK100MHZ), .CPU_RESETN(CPU_RESETN), .vsync(vsync), .BTNL(BTNL), .BTNR(BTNR),
    .restart(restart), .state(state), .logo_voffset(logo_voffset),
    .player_hoffset(player_hoffset), .player_voffset(player_voffset),
    .coin_hoffset(coin_h), .coin_voffset(coin_v)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (k=%0d)", name, act, exp, k);
    end
  endtask

  function automatic int m_state(int t);
    if (t < CF) return 0;
    if (t < T_ENTER) return 1;
    if (t < T_PLAY) return 2;
    return 3;
  endfunction

  function automatic int m_logo(int t);
    int v;
    if (t <= CF) return 0;
    v = -LS * (t - CF);
    return (v < LE) ? LE : v;
  endfunction

  function automatic int m_pv(int t);
    int v;
    if (t <= T_ENTER) return PS;
    v = PS + PST * (t - T_ENTER);
    return (v > 0) ? 0 : v;
  endfunction

  function automatic int m_phase(int t);
    return (t <= T_PLAY) ? 0 : (t - T_PLAY) % PERIOD;
  endfunction

  task automatic check_model(input string tag);
    int ph;
    ph = m_phase(k);
    check({tag, " state"}, int'(state), m_state(k));
    check({tag, " logo"}, int'(logo_voffset), m_logo(k));
    check({tag, " player_v"}, int'(player_voffset), m_pv(k));
    check({tag, " player_h"}, int'(player_hoffset), (1 - lane) * 100);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s coin_v%0d", tag, i), int'(coin_v[i]), 40 + 6 * ph);
      check($sformatf("%s coin_h%0d", tag, i), int'(coin_h[i]), 200 + i * 80 + (i - 1) * ph);
    end
  endtask

  // One vsync pulse; returns on a falling edge with the tick's results visible.
  task automatic frame(input int gap);
    @(negedge CLK100MHZ) vsync = 1'b1;
    @(negedge CLK100MHZ) vsync = 1'b0;
    repeat (gap) @(negedge CLK100MHZ);
  endtask

  task automatic press(input logic pl, input logic pr);
    @(negedge CLK100MHZ);
    BTNL = pl;
    BTNR = pr;
    repeat (2) @(negedge CLK100MHZ);
    BTNL = 1'b0;
    BTNR = 1'b0;
    repeat (3) @(negedge CLK100MHZ);
  endtask

  task automatic do_restart();
    @(negedge CLK100MHZ) restart = 1'b1;
    @(negedge CLK100MHZ) restart = 1'b0;
    k = 0;
    lane = 1;
  endtask

  typedef struct {
    logic pl;
    logic pr;
    int   nt;
    int   st;
    int   logo;
    int   pv;
    int   hoff;
  } vec_t;

  vec_t tbl [14];

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 0,  0, 0,    -170, 0};
    tbl[1]  = '{1'b1, 1'b0, 4,  0, 0,    -170, 0};
    tbl[2]  = '{1'b0, 1'b0, 1,  1, 0,    -170, 0};
    tbl[3]  = '{1'b0, 1'b1, 1,  1, -30,  -170, 0};
    tbl[4]  = '{1'b0, 1'b0, 19, 2, -600, -170, 0};
    tbl[5]  = '{1'b1, 1'b0, 9,  2, -600, -17,  0};
    tbl[6]  = '{1'b0, 1'b0, 1,  3, -600, 0,    0};
    tbl[7]  = '{1'b1, 1'b0, 1,  3, -600, 0,    100};
    tbl[8]  = '{1'b1, 1'b0, 1,  3, -600, 0,    100};
    tbl[9]  = '{1'b0, 1'b1, 1,  3, -600, 0,    0};
    tbl[10] = '{1'b0, 1'b1, 1,  3, -600, 0,    -100};
    tbl[11] = '{1'b0, 1'b1, 1,  3, -600, 0,    -100};
    tbl[12] = '{1'b1, 1'b1, 1,  3, -600, 0,    -100};
    tbl[13] = '{1'b1, 1'b0, 1,  3, -600, 0,    0};

    repeat (3) @(negedge CLK100MHZ);
    CPU_RESETN = 1'b1;
    @(negedge CLK100MHZ);

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].pl || tbl[i].pr) press(tbl[i].pl, tbl[i].pr);
      repeat (tbl[i].nt) frame(1);
      k += tbl[i].nt;
      check($sformatf("vec%0d state", i), int'(state), tbl[i].st);
      check($sformatf("vec%0d logo", i), int'(logo_voffset), tbl[i].logo);
      check($sformatf("vec%0d player_v", i), int'(player_voffset), tbl[i].pv);
      check($sformatf("vec%0d player_h", i), int'(player_hoffset), tbl[i].hoff);
    end
    lane = 1;

    // Coin phase: 73 play ticks reach the last in-range phase, the next one wraps.
    while (k < T_PLAY + 73) begin
      frame(0);
      k++;
    end
    check("phase73 coin_v", int'(coin_v[1]), 478);
    check("phase73 coin_h0", int'(coin_h[0]), 127);
    check("phase73 coin_h1", int'(coin_h[1]), 280);
    check("phase73 coin_h2", int'(coin_h[2]), 433);
    frame(2);
    k++;
    check("wrap coin_v", int'(coin_v[2]), 40);
    check("wrap coin_h0", int'(coin_h[0]), 200);
    check("wrap coin_h2", int'(coin_h[2]), 360);
    check_model("wrap");

    // Restart coinciding with a tick mid-ENTER.
    do_restart();
    repeat (30) frame(1);
    k = 30;
    check_model("enter30");
    @(negedge CLK100MHZ);
    vsync = 1'b1;
    restart = 1'b1;
    @(negedge CLK100MHZ);
    vsync = 1'b0;
    restart = 1'b0;
    k = 0;
    lane = 1;
    check("restart state", int'(state), int'(COUNTDOWN));
    check_model("restart");

    // Randomised frames against the reference model.
    for (int f = 0; f < 300; f++) begin
      logic pl, pr;
      if ($urandom_range(149) == 0) do_restart();
      pl = ($urandom_range(3) == 0);
      pr = ($urandom_range(3) == 0);
      if (pl || pr) begin
        if ($urandom_range(1) == 0) press(pl, pr);
        else begin
          if (pl) press(1'b1, 1'b0);
          if (pr) press(1'b0, 1'b1);
        end
      end
      if ($urandom_range(4) == 0 && pl) press(1'b1, 1'b0);
      frame($urandom_range(3));
      if (k >= T_PLAY) begin
        if (pl && !pr && lane > 0) lane--;
        else if (pr && !pl && lane < 2) lane++;
      end
      k++;
      check_model($sformatf("rnd%0d", f));
    end

    // Asynchronous reset mid-PLAY takes effect without a clock edge.
    do_restart();
    repeat (T_PLAY + 4) frame(0);
    k = T_PLAY + 4;
    press(1'b0, 1'b1);
    frame(1);
    k++;
    lane = 2;
    check_model("pre_reset");
    @(negedge CLK100MHZ);
    #2 CPU_RESETN = 1'b0;
    #1;
    k = 0;
    lane = 1;
    check("async state", int'(state), int'(COUNTDOWN));
    check_model("async");
    @(negedge CLK100MHZ) CPU_RESETN = 1'b1;
    frame(1);
    k = 1;
    check_model("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
